// File: rtl/ex_muldiv_unit_pkg.sv
// Shared CPU definitions for the EX-stage multiply/divide unit.
// Holds the op-code set and the default latencies of the sequencer.
package ex_muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic md_is_mult(input md_op_e op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Connection between the ID/EX register (master) and the multiply/divide unit (slave).
// The hazard unit and EX/MEM mux also watch busy, md_out, hi and lo.
interface ex_muldiv_unit_if;
  import ex_muldiv_unit_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, md_out, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, md_out, hi, lo
  );

endinterface

// File: rtl/ex_muldiv_unit_core.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Kept apart from the sequencer so an iterative divider can be dropped in later.
module muldiv_core
  import ex_muldiv_unit_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_new_o,
  output logic [31:0] lo_new_o,
  output logic        div0_o
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic        [31:0] bSafe;
  logic signed [32:0] dividendS;
  logic signed [32:0] divisorS;
  logic signed [32:0] quotS;
  logic signed [32:0] remS;
  logic        [31:0] quotU;
  logic        [31:0] remU;

  // Signed divide is done on 33 bits so 0x80000000 / -1 cannot overflow;
  // its low word is the wrapped quotient 0x80000000 with remainder 0.
  always_comb begin
    bSafe     = (b_i == 32'd0) ? 32'd1 : b_i;
    prodS     = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prodU     = {32'd0, a_i} * {32'd0, b_i};
    dividendS = $signed({a_i[31], a_i});
    divisorS  = $signed({bSafe[31], bSafe});
    quotS     = dividendS / divisorS;
    remS      = dividendS % divisorS;
    quotU     = a_i / bSafe;
    remU      = a_i % bSafe;

    hi_new_o = '0;
    lo_new_o = '0;
    div0_o   = 1'b0;
    case (op_i)
      MULT:  {hi_new_o, lo_new_o} = prodS;
      MULTU: {hi_new_o, lo_new_o} = prodU;
      DIV: begin
        lo_new_o = quotS[31:0];
        hi_new_o = remS[31:0];
        div0_o   = (b_i == 32'd0);
      end
      DIVU: begin
        lo_new_o = quotU;
        hi_new_o = remU;
        div0_o   = (b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: counter-based sequencer around muldiv_core,
// architectural HI/LO registers, MT writes and a zero-latency MF read path.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  ex_muldiv_unit_if.slave  md_if
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  md_op_e           op_q, op_d;

  logic [31:0] hiNew;
  logic [31:0] loNew;
  logic        div0;
  logic        busy;

  muldiv_core u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .hi_new_o (hiNew),
    .lo_new_o (loNew),
    .div0_o   (div0)
  );

  assign busy = (cnt_q != '0);

  // While counting, start is ignored outright; the last count commits the
  // core result unless it was a divide by zero.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    if (busy) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d = '0;
        if (!div0) begin
          hi_d = hiNew;
          lo_d = loNew;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (md_if.start) begin
      if (md_is_mult(md_if.op) || md_is_div(md_if.op)) begin
        a_d   = md_if.rs_val;
        b_d   = md_if.rt_val;
        op_d  = md_if.op;
        cnt_d = md_is_mult(md_if.op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (md_if.op == MTHI) begin
        hi_d = md_if.rs_val;
      end else if (md_if.op == MTLO) begin
        lo_d = md_if.rs_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_NONE;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
    end
  end

  assign md_if.busy   = busy;
  assign md_if.hi     = hi_q;
  assign md_if.lo     = lo_q;
  assign md_if.md_out = (md_if.op == MFHI) ? hi_q :
                        (md_if.op == MFLO) ? lo_q : 32'd0;

endmodule
